// File: rtl/gate_state_mac_pkg.sv
// Shared types for the sequential gate x state engine: Q2.6 complex number, widths, FSM states.
package complex_pkg;

  localparam int unsigned CN_W    = 8;
  localparam int unsigned CN_FRAC = 6;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned SUM_W   = PROD_W + 1;

  typedef struct packed {
    logic signed [CN_W-1:0] a;
    logic signed [CN_W-1:0] b;
  } complexNum;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_t;

endpackage

// File: rtl/gate_state_mac_if.sv
// Request/result bundle between the gate/state storage and the MAC engine.
interface gate_state_mac_if #(
  parameter int unsigned NUM_QUBITS = 1
);
  import complex_pkg::*;

  localparam int unsigned DIM = 1 << NUM_QUBITS;

  logic      start;
  complexNum state_in [DIM];
  complexNum gate_in  [DIM][DIM];
  logic      busy;
  logic      done;
  complexNum out_state [DIM];

  modport master (output start, state_in, gate_in, input busy, done, out_state);
  modport slave  (input start, state_in, gate_in, output busy, done, out_state);

endinterface

// File: rtl/gate_state_mac_complex_mult.sv
// One complex multiply with a single register stage; Q2.6 x Q2.6 -> Q4.12 partials, 17-bit sums.
module complex_mult
  import complex_pkg::*;
(
  input  logic                    clk,
  input  complexNum               x,
  input  complexNum               y,
  output logic signed [SUM_W-1:0] re,
  output logic signed [SUM_W-1:0] im
);

  logic signed [PROD_W-1:0] ac, bd, ad, bc;

  always_comb begin
    ac = PROD_W'(x.a) * PROD_W'(y.a);
    bd = PROD_W'(x.b) * PROD_W'(y.b);
    ad = PROD_W'(x.a) * PROD_W'(y.b);
    bc = PROD_W'(x.b) * PROD_W'(y.a);
  end

  always_ff @(posedge clk) begin
    re <= SUM_W'(ac) - SUM_W'(bd);
    im <= SUM_W'(ad) + SUM_W'(bc);
  end

endmodule

// File: rtl/gate_state_mac.sv
// Sequential complex matrix-vector product out_state = gate x state, one MAC per cycle.
// Build option GATE_STATE_SAT_EN: saturate instead of wrap when narrowing row results.
module gate_state_mac
  import complex_pkg::*;
#(
  parameter int unsigned NUM_QUBITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  gate_state_mac_if.slave bus
);

  localparam int unsigned DIM   = 1 << NUM_QUBITS;
  localparam int unsigned IDX_W = 2 * NUM_QUBITS;
  localparam int unsigned ACC_W = SUM_W + NUM_QUBITS;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DIM * DIM - 1);
  localparam logic [NUM_QUBITS-1:0] LAST_J   = NUM_QUBITS'(DIM - 1);

  mac_state_t state_q, state_n;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_QUBITS-1:0] iss_i, iss_j;
  logic                  p_vld;
  logic [NUM_QUBITS-1:0] p_i, p_j;
  logic                  busy_q, done_q;

  complexNum state_lat [DIM];
  complexNum gate_lat  [DIM][DIM];
  complexNum mult_x, mult_y;
  complexNum shadow_q [DIM];
  complexNum shadow_n [DIM];
  complexNum out_q    [DIM];

  logic signed [SUM_W-1:0] m_re, m_im;
  logic signed [ACC_W-1:0] acc_re, acc_im, sum_re, sum_im;

  // Round half-up at the Q4.12 -> Q2.6 boundary, then narrow to 8 bits
  function automatic logic signed [CN_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    r = (v + ACC_W'(1 << (CN_FRAC - 1))) >>> CN_FRAC;
`ifdef GATE_STATE_SAT_EN
    if (r > ACC_W'(127))       return 8'sh7F;
    else if (r < ACC_W'(-128)) return 8'sh80;
`endif
    return CN_W'(r);
  endfunction

  assign iss_i  = idx_q[IDX_W-1:NUM_QUBITS];
  assign iss_j  = idx_q[NUM_QUBITS-1:0];
  assign mult_x = gate_lat[iss_i][iss_j];
  assign mult_y = state_lat[iss_j];

  complex_mult u_mult (
    .clk (clk),
    .x   (mult_x),
    .y   (mult_y),
    .re  (m_re),
    .im  (m_im)
  );

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (idx_q == LAST_IDX) state_n = DRAIN;
      DRAIN:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Accumulate the product leaving the multiplier; the j=0 product restarts the row
  always_comb begin
    sum_re   = ((p_j == '0) ? '0 : acc_re) + ACC_W'(m_re);
    sum_im   = ((p_j == '0) ? '0 : acc_im) + ACC_W'(m_im);
    shadow_n = shadow_q;
    if (p_vld && (p_j == LAST_J)) begin
      shadow_n[p_i].a = narrow(sum_re);
      shadow_n[p_i].b = narrow(sum_im);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      p_vld   <= 1'b0;
      p_i     <= '0;
      p_j     <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < int'(DIM); k++) begin
        shadow_q[k] <= '0;
        out_q[k]    <= '0;
      end
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n == RUN) || (state_n == DRAIN);
      done_q  <= (state_n == DONE);
      p_vld   <= (state_q == RUN);
      p_i     <= iss_i;
      p_j     <= iss_j;
      idx_q   <= (state_q == RUN) ? idx_q + IDX_W'(1) : '0;
      if (p_vld) begin
        acc_re <= sum_re;
        acc_im <= sum_im;
      end
      shadow_q <= shadow_n;
      // Last row closes in DRAIN, so publish the post-write shadow on entry to DONE
      if (state_n == DONE) out_q <= shadow_n;
    end
  end

  // Operand capture happens only on accept; operands need no reset
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      state_lat <= bus.state_in;
      gate_lat  <= bus.gate_in;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_state = out_q;

endmodule

// File: tb/tb_gate_state_mac.sv
// Directed bench for gate_state_mac: N=1 vector table plus N=2 back-to-back and abort sequences.
module tb_gate_state_mac;
  import complex_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gate_state_mac_if #(.NUM_QUBITS(1)) bus1 ();
  gate_state_mac_if #(.NUM_QUBITS(2)) bus2 ();

  gate_state_mac #(.NUM_QUBITS(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  gate_state_mac #(.NUM_QUBITS(2)) u2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0][7:0] gre;   // index i*2+j
    logic [3:0][7:0] gim;
    logic [1:0][7:0] sre;
    logic [1:0][7:0] sim;
    logic [1:0][7:0] ere;
    logic [1:0][7:0] eim;
  } vec_t;

`ifdef GATE_STATE_SAT_EN
  localparam logic [7:0] SAT_E = 8'h7F;
`else
  localparam logic [7:0] SAT_E = 8'hC0;
`endif

  vec_t      vt [6];
  complexNum g_m [4][4];
  complexNum s_m [4];
  complexNum e_m [2][4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm_narrow(input int acc);
    int r;
    r = (acc + 32) >>> 6;
`ifdef GATE_STATE_SAT_EN
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
`endif
    return 8'(r);
  endfunction

  function automatic void golden2(input int w);
    for (int i = 0; i < 4; i++) begin
      int ar, ai;
      ar = 0;
      ai = 0;
      for (int j = 0; j < 4; j++) begin
        ar += int'(g_m[i][j].a) * int'(s_m[j].a) - int'(g_m[i][j].b) * int'(s_m[j].b);
        ai += int'(g_m[i][j].a) * int'(s_m[j].b) + int'(g_m[i][j].b) * int'(s_m[j].a);
      end
      e_m[w][i].a = gm_narrow(ar);
      e_m[w][i].b = gm_narrow(ai);
    end
  endfunction

  task automatic load_rand2();
    for (int i = 0; i < 4; i++) begin
      s_m[i] = complexNum'(16'($urandom));
      for (int j = 0; j < 4; j++) g_m[i][j] = complexNum'(16'($urandom));
    end
  endtask

  task automatic drive2();
    for (int i = 0; i < 4; i++) begin
      bus2.state_in[i] = s_m[i];
      for (int j = 0; j < 4; j++) bus2.gate_in[i][j] = g_m[i][j];
    end
  endtask

  task automatic cmp2(input int w, input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s out[%0d]", tag, k), 32'(bus2.out_state[k]), 32'(e_m[w][k]));
  endtask

  task automatic run1(input vec_t v, input int id);
    int cyc;
    @(negedge clk);
    bus1.start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus1.gate_in[k / 2][k % 2].a = v.gre[k];
      bus1.gate_in[k / 2][k % 2].b = v.gim[k];
    end
    for (int j = 0; j < 2; j++) begin
      bus1.state_in[j].a = v.sre[j];
      bus1.state_in[j].b = v.sim[j];
    end
    @(posedge clk); #1;
    cyc = 1;
    bus1.start = 1'b0;
    for (int k = 0; k < 4; k++) bus1.gate_in[k / 2][k % 2] = complexNum'(16'($urandom));
    for (int j = 0; j < 2; j++) bus1.state_in[j] = complexNum'(16'($urandom));
    check($sformatf("v%0d busy after accept", id), 32'(bus1.busy), 32'd1);
    while (!bus1.done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("v%0d done latency", id), 32'(cyc), 32'd6);
    for (int j = 0; j < 2; j++)
      check($sformatf("v%0d out[%0d]", id, j), 32'(bus1.out_state[j]), 32'({v.ere[j], v.eim[j]}));
    @(posedge clk); #1;
    check($sformatf("v%0d done pulse width", id), 32'(bus1.done), 32'd0);
    check($sformatf("v%0d out[0] held", id), 32'(bus1.out_state[0]), 32'({v.ere[0], v.eim[0]}));
  endtask

  initial begin
    int done_n;
    vt[0] = '{gre: {8'h40, 8'h00, 8'h00, 8'h40}, gim: '0, sre: {8'h00, 8'h40}, sim: '0,
              ere: {8'h00, 8'h40}, eim: '0};
    vt[1] = '{gre: {8'h20, 8'h20, 8'h20, 8'h20}, gim: '0, sre: {8'h00, 8'h40}, sim: '0,
              ere: {8'h20, 8'h20}, eim: '0};
    vt[2] = '{gre: '0, gim: {8'h00, 8'h00, 8'h00, 8'h20}, sre: '0, sim: {8'h00, 8'h20},
              ere: {8'h00, 8'hF0}, eim: '0};
    vt[3] = '{gre: {8'h40, 8'h40, 8'h40, 8'h40}, gim: '0, sre: {8'h60, 8'h60}, sim: '0,
              ere: {SAT_E, SAT_E}, eim: '0};
    vt[4] = '{gre: {8'h00, 8'h40, 8'h40, 8'h00}, gim: '0, sre: {8'h20, 8'h10}, sim: {8'h08, 8'hF0},
              ere: {8'h10, 8'h20}, eim: {8'hF0, 8'h08}};
    vt[5] = '{gre: {8'h00, 8'hFF, 8'h00, 8'h01}, gim: '0, sre: {8'h00, 8'h20}, sim: '0,
              ere: {8'h00, 8'h01}, eim: '0};

    reset = 1'b1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus1.state_in[i] = '0;
      for (int j = 0; j < 2; j++) bus1.gate_in[i][j] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      bus2.state_in[i] = '0;
      for (int j = 0; j < 4; j++) bus2.gate_in[i][j] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset busy n1", 32'(bus1.busy), 32'd0);
    check("reset done n1", 32'(bus1.done), 32'd0);
    check("reset busy n2", 32'(bus2.busy), 32'd0);
    check("reset done n2", 32'(bus2.done), 32'd0);
    for (int k = 0; k < 2; k++) check($sformatf("reset n1 out[%0d]", k), 32'(bus1.out_state[k]), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("reset n2 out[%0d]", k), 32'(bus2.out_state[k]), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) run1(vt[v], v);

    // Back-to-back with start held: first accepted at 0, second in the cycle after DONE
    load_rand2();
    golden2(0);
    @(negedge clk);
    drive2();
    bus2.start = 1'b1;
    @(posedge clk); #1;
    load_rand2();
    golden2(1);
    drive2();
    done_n = 0;
    for (int cyc = 2; cyc <= 46; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 21) bus2.start = 1'b0;
      if (bus2.done) begin
        done_n++;
        if (done_n == 1) begin
          check("b2b first done cycle", 32'(cyc), 32'd18);
          cmp2(0, "b2b first");
        end else if (done_n == 2) begin
          check("b2b second done cycle", 32'(cyc), 32'd37);
          cmp2(1, "b2b second");
        end
      end
    end
    check("b2b done count", 32'(done_n), 32'd2);

    // Abort: extra start mid-RUN, reset during cycle 8
    load_rand2();
    @(negedge clk);
    drive2();
    bus2.start = 1'b1;
    done_n = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      bus2.start = (cyc == 4);
      if (bus2.done) done_n++;
      check($sformatf("abort busy c%0d", cyc), 32'(bus2.busy), 32'd1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy after reset", 32'(bus2.busy), 32'd0);
    check("abort done after reset", 32'(bus2.done), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("abort out[%0d]", k), 32'(bus2.out_state[k]), 32'd0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (bus2.done) done_n++;
    end
    check("abort no done", 32'(done_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
